// File: rtl/obi_tb_pkg.sv
// Shared definitions for the OBI data responder: stall-LFSR polynomial and seed,
// the response-queue entry layout, and the LFSR step function.
package obi_tb_pkg;

  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_0001;

  // Age must hold RVALID_MIN_LAT up to 4.
  localparam int AGE_W = 3;

  typedef struct packed {
    logic             is_write;
    logic [31:0]      rdata;
    logic [AGE_W-1:0] age;
  } resp_entry_t;

  localparam int RESP_ENTRY_W = $bits(resp_entry_t);

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue. Each slot carries an age field in its low AGE_W bits
// that counts cycles since the push and saturates at AGE_MAX.
module obi_resp_fifo #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 36,
  parameter int AGE_W   = 3,
  parameter int AGE_MAX = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = slot_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // NOTE: slot storage is deliberately not reset; the pointers and count define
  // which slots are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_ptr_q == PTR_W'(i))) begin
        slot_q[i] <= push_data_i;
      end else if (slot_q[i][AGE_W-1:0] < AGE_SAT) begin
        slot_q[i][AGE_W-1:0] <= slot_q[i][AGE_W-1:0] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/obi_data_responder.sv
// OBI data-side responder: word RAM with byte enables, in-order response queue
// with a minimum grant-to-rvalid latency, and optional LFSR-driven stalls.
module obi_data_responder
  import obi_tb_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH  = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] LFSR_SEED       = LFSR_DEFAULT_SEED,
  parameter int          RVALID_MIN_LAT  = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               data_req_i,
  input  logic [31:0]                        data_addr_i,
  input  logic                               data_we_i,
  input  logic [3:0]                         data_be_i,
  input  logic [31:0]                        data_wdata_i,
  input  logic                               stall_en_i,
  output logic                               data_gnt_o,
  output logic                               data_rvalid_o,
  output logic [31:0]                        data_rdata_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  localparam int RAM_WORDS = 2 ** (RAM_ADDR_WIDTH - 2);

  logic [31:0]               ram_q [RAM_WORDS];
  logic [RAM_ADDR_WIDTH-3:0] word_idx;
  logic [31:0]               lfsr_q;
  logic                      transfer;
  logic                      fifo_full;
  logic                      fifo_empty;
  resp_entry_t               push_entry;
  resp_entry_t               head_entry;
  logic                      pop;
  logic                      unused_addr_bits;

  assign word_idx         = data_addr_i[RAM_ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0]};

  // Grant is held low during reset so nothing is pushed while the queue is cleared.
  assign data_gnt_o = rst_ni && data_req_i && !fifo_full && !(stall_en_i && lfsr_q[0]);
  assign transfer   = data_gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_next(lfsr_q);
  end

  // RAM survives reset; only byte lanes with their enable set are written.
  always_ff @(posedge clk_i) begin
    if (transfer && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) ram_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // The read word is taken from pre-edge RAM; the entry becomes visible one
  // cycle after the grant, so it starts life with age 1.
  always_comb begin
    push_entry.is_write = data_we_i;
    push_entry.rdata    = data_we_i ? 32'h0 : ram_q[word_idx];
    push_entry.age      = AGE_W'(1);
  end

  obi_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .WIDTH   (RESP_ENTRY_W),
    .AGE_W   (AGE_W),
    .AGE_MAX (RVALID_MIN_LAT)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (transfer),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding_o)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    if (!fifo_empty && (head_entry.age >= AGE_W'(RVALID_MIN_LAT)) &&
        !(stall_en_i && lfsr_q[1])) begin
      data_rvalid_o = 1'b1;
      data_rdata_o  = head_entry.is_write ? 32'h0 : head_entry.rdata;
    end
  end

  // No ready from the core: a presented response is consumed immediately.
  assign pop = data_rvalid_o;

endmodule

// File: tb/tb_obi_data_responder.sv
// Bench for obi_data_responder: two instances (min latency 1 and 4) share stimulus;
// a timestamp/byte-memory model checks every cycle, plus directed literal checks.
module tb_obi_data_responder;
  import obi_tb_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall_en;

  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [2:0]  a_out, b_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  obi_data_responder #(.RAM_ADDR_WIDTH(AW), .MAX_OUTSTANDING(DEPTH), .RVALID_MIN_LAT(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_en_i(stall_en), .data_gnt_o(a_gnt),
    .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata), .outstanding_o(a_out));

  obi_data_responder #(.RAM_ADDR_WIDTH(AW), .MAX_OUTSTANDING(DEPTH), .RVALID_MIN_LAT(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .stall_en_i(stall_en), .data_gnt_o(b_gnt),
    .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata), .outstanding_o(b_out));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // ---------------- behavioural model ----------------
  // Each outstanding response is remembered with the cycle it was granted in.
  logic [7:0]  mmem   [2][4096];
  int          q_gcyc [2][16];
  logic        q_we   [2][16];
  logic [31:0] q_rd   [2][16];
  int          q_head [2];
  int          q_cnt  [2];
  int          cyc;
  logic [31:0] mlfsr;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      q_head[i] = 0;
      q_cnt[i]  = 0;
    end
    cyc   = 0;
    mlfsr = LFSR_DEFAULT_SEED;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        act_gnt, act_rv, exp_gnt, exp_rv;
      logic [31:0] act_rd, exp_rd, word;
      logic [2:0]  act_out;
      int          exp_out, base;
      string       sfx;
      sfx     = (i == 0) ? "a" : "b";
      act_gnt = (i == 0) ? a_gnt : b_gnt;
      act_rv  = (i == 0) ? a_rvalid : b_rvalid;
      act_rd  = (i == 0) ? a_rdata : b_rdata;
      act_out = (i == 0) ? a_out : b_out;
      exp_gnt = 1'b0;
      exp_rv  = 1'b0;
      exp_rd  = 32'h0;
      exp_out = 0;
      if (rst_n) begin
        exp_out = q_cnt[i];
        exp_gnt = req && (q_cnt[i] < DEPTH) && !(stall_en && mlfsr[0]);
        exp_rv  = (q_cnt[i] > 0) && ((cyc - q_gcyc[i][q_head[i]]) >= lat_of(i)) &&
                  !(stall_en && mlfsr[1]);
        if (exp_rv && !q_we[i][q_head[i]]) exp_rd = q_rd[i][q_head[i]];
      end
      check({"model_gnt_", sfx}, {31'h0, act_gnt}, {31'h0, exp_gnt});
      check({"model_rvalid_", sfx}, {31'h0, act_rv}, {31'h0, exp_rv});
      check({"model_rdata_", sfx}, act_rd, exp_rd);
      check({"model_outstanding_", sfx}, {29'h0, act_out}, 32'(exp_out));
      if (rst_n) begin
        if (exp_rv) begin
          q_head[i] = (q_head[i] + 1) % 16;
          q_cnt[i]--;
        end
        if (exp_gnt) begin
          int slot;
          base = int'({addr[AW-1:2], 2'b00});
          for (int b = 0; b < 4; b++) word[8*b +: 8] = mmem[i][base + b];
          slot = (q_head[i] + q_cnt[i]) % 16;
          q_gcyc[i][slot] = cyc;
          q_we[i][slot]   = we;
          q_rd[i][slot]   = word;
          q_cnt[i]++;
          if (we) for (int b = 0; b < 4; b++) if (be[b]) mmem[i][base + b] = wdata[8*b +: 8];
        end
      end else begin
        q_head[i] = 0;
        q_cnt[i]  = 0;
      end
    end
    if (rst_n) begin
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ LFSR_POLY) : (mlfsr >> 1);
      cyc++;
    end else begin
      mlfsr = LFSR_DEFAULT_SEED;
      cyc   = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] e, input logic [31:0] d);
    @(posedge clk);
    #1;
    req = r; we = w; addr = a; be = e; wdata = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic gnt_hist [40];
  logic rv_hist  [40];
  int   out_hist [40];
  logic [31:0] rv_data [8];

  initial begin
    int k, nrv, peak, a_gc, a_rc, b_gc, b_rc, n;
    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    stall_en = 1'b0;

    // Reset: grant held low even with a request pending.
    at_neg();
    check("reset_gnt", {31'h0, a_gnt}, 32'h0);
    check("reset_outstanding", {29'h0, a_out}, 32'h0);
    check("reset_rvalid", {31'h0, b_rvalid}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1; req = 1'b0;

    // Fill the low 64 words; spacing keeps the latency-4 queue from filling.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, 32'(i * 4), 4'hF, init_word(i));
      idle(4);
    end

    // Full write then read at 0x100 on the latency-1 instance.
    step(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    at_neg(); check("wr100_gnt", {31'h0, a_gnt}, 32'h1);
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    at_neg(); check("rd100_gnt", {31'h0, a_gnt}, 32'h1);
    check("wr100_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("wr100_rdata", a_rdata, 32'h0);
    idle(1);
    at_neg(); check("rd100_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("rd100_rdata", a_rdata, 32'hDEAD_BEEF);
    idle(5);

    // Partial write with be=0101 over an all-ones word.
    step(1'b1, 1'b1, 32'h200, 4'hF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h200, 4'b0101, 32'h1122_3344);
    step(1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    idle(1);
    at_neg(); check("be_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("be_rdata", a_rdata, 32'hFF22_FF44);
    idle(5);

    // Six back-to-back reads against the latency-4 instance.
    k = 0; nrv = 0; peak = 0;
    for (int c = 0; c < 40; c++) begin
      if (k < 6) step(1'b1, 1'b0, 32'(k * 4), 4'h0, 32'h0);
      else       idle(1);
      at_neg();
      gnt_hist[c] = b_gnt;
      rv_hist[c]  = b_rvalid;
      out_hist[c] = int'(b_out);
      if (int'(b_out) > peak) peak = int'(b_out);
      if (b_gnt) k++;
      if (b_rvalid && nrv < 8) begin
        rv_data[nrv] = b_rdata;
        nrv++;
      end
      if (k == 6 && b_out == 0) break;
    end
    check("b2b_grants", 32'(k), 32'd6);
    check("b2b_peak", 32'(peak), 32'd4);
    check("b2b_gnt_when_full", {31'h0, gnt_hist[4]}, 32'h0);
    check("b2b_rvalid_when_full", {31'h0, rv_hist[4]}, 32'h1);
    check("b2b_out_full", 32'(out_hist[4]), 32'd4);
    check("pushpop_gnt", {31'h0, gnt_hist[5]}, 32'h1);
    check("pushpop_rvalid", {31'h0, rv_hist[5]}, 32'h1);
    check("pushpop_out_before", 32'(out_hist[5]), 32'd3);
    check("pushpop_out_after", 32'(out_hist[6]), 32'd3);
    check("b2b_rvalids", 32'(nrv), 32'd6);
    for (int i = 0; i < 6; i++) check("b2b_order", rv_data[i], init_word(i));
    idle(5);

    // Reset with three responses outstanding on the latency-4 instance.
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    step(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    step(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    idle(1);
    at_neg(); check("pre_reset_out", {29'h0, b_out}, 32'd3);
    @(posedge clk); #1; rst_n = 1'b0; req = 1'b0;
    at_neg(); check("mid_reset_out", {29'h0, b_out}, 32'd0);
    check("mid_reset_rvalid", {31'h0, b_rvalid}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    idle(1);
    at_neg(); check("post_reset_rdata_a", a_rdata, 32'hDEAD_BEEF);
    idle(3);
    at_neg(); check("post_reset_rdata_b", b_rdata, 32'hDEAD_BEEF);
    idle(5);

    // Random traffic with stalls enabled.
    stall_en = 1'b1;
    a_gc = 0; a_rc = 0; b_gc = 0; b_rc = 0; n = 0;
    while (a_gc < 1000 && n < 8000) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 63) * 4), 4'($urandom_range(0, 15)), $urandom);
      at_neg();
      a_gc += int'(a_gnt); a_rc += int'(a_rvalid);
      b_gc += int'(b_gnt); b_rc += int'(b_rvalid);
      n++;
    end
    stall_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      idle(1);
      at_neg();
      a_rc += int'(a_rvalid); b_rc += int'(b_rvalid);
    end
    check("rand_enough_grants", {31'h0, (a_gc >= 1000)}, 32'h1);
    check("rand_rvalid_count_a", 32'(a_rc), 32'(a_gc));
    check("rand_rvalid_count_b", 32'(b_rc), 32'(b_gc));
    check("rand_drained_a", {29'h0, a_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
